instr_fetch_unit: RTL and testbench

- Front end of the RV32I core. Fetches 32-bit instructions from instruction memory over a req/ack interface and buffers them with their PC in a small queue.
- Presents the queue head to the decoder/control path, which consumes it with a valid/ready handshake.
- Consumes the branch decision (pc_src) and branch offset produced by the control path: it redirects the fetch PC and flushes wrong-path instructions.

---
 rtl/rv_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_queue.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: widths, reset vector, major opcodes and
// the fetch-unit state encoding.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus the
// decoder-facing valid/ready port with branch redirect inputs.
interface instr_fetch_unit_if
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = rv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_out;
    logic            instr_ready;
    logic            pc_src;
    logic [XLEN-1:0] imm_ext;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out,
        input  imem_ack, imem_rdata, instr_ready, pc_src, imm_ext
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out,
        output imem_ack, imem_rdata, instr_ready, pc_src, imm_ext
    );
endinterface

// File: rtl/instr_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a single-cycle flush;
// the head is driven from storage registers only.
module instr_queue
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: one outstanding imem request at a time, a {pc, instr}
// queue toward the decoder, and branch redirect with wrong-path flush/drain.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned      XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = rv_pkg::RESET_PC,
    parameter int unsigned      QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic            consume, redirect, ack_acc, hold;
    logic            q_push, q_valid;
    logic [CW-1:0]   q_count, count_after;
    logic [XLEN-1:0] head_pc, head_instr, sum, target;

    assign consume  = q_valid & bus.instr_ready;
    assign redirect = consume & bus.pc_src;
    assign ack_acc  = req_q & bus.imem_ack;
    assign hold     = req_q & ~bus.imem_ack;
    assign sum      = head_pc + bus.imm_ext;
    assign target   = {sum[XLEN-1:2], 2'b00};

    // Responses are only kept in FETCH and never alongside a redirect: the
    // redirecting edge throws away whatever arrives with it.
    assign q_push      = (state_q == FETCH) & ack_acc & ~redirect;
    assign count_after = q_count + CW'(q_push) - CW'(consume);

    instr_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (q_push),
        .push_data  ({addr_q, bus.imem_rdata}),
        .pop        (consume),
        .head_valid (q_valid),
        .head_data  ({head_pc, head_instr}),
        .count      (q_count)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    req_d      = 1'b1;
                    if (hold) begin
                        state_d = DRAIN;
                    end
                end else begin
                    if (ack_acc) begin
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                    req_d = hold | (count_after < CW'(QDEPTH));
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
        // An unacked request keeps its address even when fetch_pc moves on.
        addr_d = hold ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = q_valid;
    assign bus.instr       = head_instr;
    assign bus.pc_out      = head_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed redirect/reset scenarios
// plus a randomized run checked against an expected-PC stream model.
module tb_instr_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The queue must never be pushed while already holding QDEPTH entries.
    always begin
        @(negedge clk);
        #4;
        if (rst_n === 1'b1 && dut.q_push === 1'b1 && dut.q_count == 2'd2) begin
            miscompares++;
            $display("FAIL queue_overflow: push while count=%0d (required < 2)", dut.q_count);
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ DMASK;
    endfunction

    task automatic set_idle();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'b0;
        bus.imm_ext     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Zero-latency memory: acknowledge whatever request is currently up.
    task automatic step_mem(input logic rdy);
        bus.imem_ack    = bus.imem_req;
        bus.imem_rdata  = mem_word(bus.imem_addr);
        bus.instr_ready = rdy;
        bus.pc_src      = 1'b0;
        @(negedge clk);
    endtask

    task automatic stream_to_c();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid && bus.pc_out == 32'hC) begin
                found = 1;
                break;
            end
            step_mem(1'b1);
        end
        vectors++;
        if (!found || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL setup_head_c: found=%0d req=%b addr=%h (required found=1 req=1 addr=00000010)",
                     found, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b required 0", bus.imem_req); end
        vectors++;
        if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h required 00000000", bus.imem_addr); end
        vectors++;
        if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", bus.instr_valid); end
        vectors++;
        if (bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_head: instr=%h pc=%h required 0/0", bus.instr, bus.pc_out);
        end
    endtask

    task automatic test_stream();
        do_reset();
        step_mem(1'b1);
        for (int c = 1; c <= 7; c++) begin
            vectors++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * (c - 1))) begin
                miscompares++;
                $display("FAIL stream_addr c=%0d: req=%b addr=%h required 1/%h", c, bus.imem_req, bus.imem_addr, 32'(4 * (c - 1)));
            end
            vectors++;
            if (c == 1) begin
                if (bus.instr_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_first_valid: got %b required 0", bus.instr_valid);
                end
            end else if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'(4 * (c - 2)) ||
                         bus.instr !== mem_word(32'(4 * (c - 2)))) begin
                miscompares++;
                $display("FAIL stream_head c=%0d: v=%b pc=%h instr=%h required 1/%h/%h", c, bus.instr_valid,
                         bus.pc_out, bus.instr, 32'(4 * (c - 2)), mem_word(32'(4 * (c - 2))));
            end
            step_mem(1'b1);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req) begin
                vectors++;
                if (bus.imem_addr !== 32'(4 * n_acc)) begin
                    miscompares++;
                    $display("FAIL bp_addr: got %h required %h", bus.imem_addr, 32'(4 * n_acc));
                end
                n_acc++;
            end
            step_mem(1'b0);
        end
        vectors++;
        if (n_acc != 2 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_full: fetched=%0d req=%b v=%b pc=%h required 2/0/1/00000000",
                     n_acc, bus.imem_req, bus.instr_valid, bus.pc_out);
        end
        step_mem(1'b1);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.pc_out !== 32'h4) begin
            miscompares++;
            $display("FAIL bp_resume: req=%b addr=%h pc=%h required 1/00000008/00000004",
                     bus.imem_req, bus.imem_addr, bus.pc_out);
        end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        repeat (6) step_mem(1'b0);
        set_idle();
        bus.instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        repeat (6) step_mem(1'b0);
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h8) begin
            miscompares++;
            $display("FAIL ri_setup: req=%b v=%b pc=%h required 0/1/00000008", bus.imem_req, bus.instr_valid, bus.pc_out);
        end
        set_idle();
        bus.instr_ready = 1'b1;
        bus.pc_src      = 1'b1;
        bus.imm_ext     = -32'sd8;
        @(negedge clk);
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL ri_flush: v=%b req=%b addr=%h required 0/1/00000000", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        set_idle();
        step_mem(1'b0);
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0 || bus.instr !== mem_word(32'h0)) begin
            miscompares++;
            $display("FAIL ri_target: v=%b pc=%h instr=%h required 1/00000000/%h", bus.instr_valid, bus.pc_out, bus.instr, mem_word(32'h0));
        end
    endtask

    task automatic test_redirect_drain();
        bit seen = 0;
        stream_to_c();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_src      = 1'b1;
        bus.imm_ext     = 32'hF8;
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
                miscompares++;
                $display("FAIL rd_hold%0d: v=%b req=%b addr=%h required 0/1/00000010", i, bus.instr_valid, bus.imem_req, bus.imem_addr);
            end
            if (i < 2) @(negedge clk);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(32'h10);
        @(negedge clk);
        set_idle();
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_discard: v=%b pc=%h required valid 0", bus.instr_valid, bus.pc_out);
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.imem_req) begin seen = 1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!seen || bus.imem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL rd_next_req: seen=%0d addr=%h required 1/00000104", seen, bus.imem_addr);
        end
        step_mem(1'b0);
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h104 || bus.instr !== mem_word(32'h104)) begin
            miscompares++;
            $display("FAIL rd_target: v=%b pc=%h instr=%h required 1/00000104/%h", bus.instr_valid, bus.pc_out, bus.instr, mem_word(32'h104));
        end
    endtask

    task automatic test_redirect_ack();
        stream_to_c();
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = mem_word(32'h10);
        bus.instr_ready = 1'b1;
        bus.pc_src      = 1'b1;
        bus.imm_ext     = 32'h37;
        @(negedge clk);
        set_idle();
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL ra_flush: v=%b req=%b addr=%h required 0/1/00000040", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        step_mem(1'b0);
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h40 || bus.instr !== mem_word(32'h40)) begin
            miscompares++;
            $display("FAIL ra_target: v=%b pc=%h instr=%h required 1/00000040/%h", bus.instr_valid, bus.pc_out, bus.instr, mem_word(32'h40));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step_mem(1'b0);
        step_mem(1'b0);
        set_idle();
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_setup: req=%b addr=%h v=%b required 1/00000004/1", bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0 ||
            bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rm_async: req=%b addr=%h v=%b instr=%h pc=%h required all 0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.pc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rm_restart: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    // Model: the decoder must see the architectural PC stream -- RESET_PC,
    // then +4 per consume, or the aligned branch target when pc_src is set.
    task automatic test_random();
        logic [31:0] exp_pc    = 32'h0;
        logic        prev_req  = 1'b0;
        logic        prev_ack  = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        int          consumed  = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.instr_valid) begin
                vectors++;
                if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
                    miscompares++;
                    $display("FAIL rand_head cyc=%0d: pc=%h instr=%h required %h/%h", cyc, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
                end
            end
            if (prev_req && !prev_ack) begin
                vectors++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    miscompares++;
                    $display("FAIL rand_req_hold cyc=%0d: req=%b addr=%h required 1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr);
                end
            end
            bus.imem_ack    = ($urandom % 2) == 0;
            bus.imem_rdata  = bus.imem_req ? mem_word(bus.imem_addr) : $urandom;
            bus.instr_ready = ($urandom % 4) != 0;
            bus.pc_src      = ($urandom % 5) == 0;
            case ($urandom % 3)
                0:       bus.imm_ext = 32'($urandom_range(0, 128)) - 32'd64;
                1:       bus.imm_ext = $urandom;
                default: bus.imm_ext = 32'($urandom_range(0, 15)) - 32'd7;
            endcase
            if (bus.instr_valid && bus.instr_ready) begin
                consumed++;
                exp_pc = bus.pc_src ? ((exp_pc + bus.imm_ext) & ~32'd3) : exp_pc + 32'd4;
            end
            prev_req  = bus.imem_req;
            prev_ack  = bus.imem_ack;
            prev_addr = bus.imem_addr;
            @(negedge clk);
        end
        vectors++;
        if (consumed < 300) begin
            miscompares++;
            $display("FAIL rand_progress: consumed=%0d required >= 300", consumed);
        end
        set_idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_idle();
        test_redirect_drain();
        test_redirect_ack();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
